// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier.
// Retires one multiplier bit pair {B[i], B[i-1]} per clock and adds, subtracts
// or skips the sign-extended multiplicand shifted left by i. The full product,
// its low half and an overflow flag are registered on completion.
// Optional build macro: MULT_EARLY_TERM_EN (finish as soon as the remaining
// multiplier bits can no longer cause an add or subtract).
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CW    = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     data_operandA,
  input  logic [WIDTH-1:0]     data_operandB,
  input  logic                 ctrl_start,
  output logic [WIDTH-1:0]     data_result,
  output logic [2*WIDTH-1:0]   data_product,
  output logic                 data_exception,
  output logic                 data_resultRDY,
  output logic                 busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     a_reg, a_next;
  // Multiplier with the implicit B[-1]=0 appended at bit 0.
  logic [WIDTH:0]       b_reg, b_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   prod_reg, prod_next;
  logic                 exc_reg, exc_next;
  logic                 rdy_reg, rdy_next;

  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   acc_step;
  logic [1:0]           pair;
  logic [WIDTH:0]       prod_top;
  logic                 last_step;

  // One Booth step: select add/sub/skip of A<<i from the current bit pair.
  always_comb begin
    addend = {{WIDTH{a_reg[WIDTH-1]}}, a_reg} << cnt_reg;
    pair   = b_reg[cnt_reg +: 2];
    case (pair)
      2'b01:   acc_step = acc_reg + addend;
      2'b10:   acc_step = acc_reg - addend;
      default: acc_step = acc_reg;
    endcase
    prod_top = acc_step[2*WIDTH-1:WIDTH-1];
  end

`ifdef MULT_EARLY_TERM_EN
  // pair_eq[gi] is 1 when bit pair gi ({B[gi], B[gi-1]}) would be a skip.
  logic [WIDTH-1:0] pair_eq;
  logic [CW:0]      next_idx;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pair_eq
      assign pair_eq[gi] = (b_reg[gi+1] == b_reg[gi]);
    end
  endgenerate

  // Done once every pair after the current one is a skip, i.e. the
  // unprocessed multiplier bits are all zeros or all ones.
  always_comb begin
    next_idx  = {1'b0, cnt_reg} + 1'b1;
    last_step = ~|((~pair_eq) >> next_idx);
  end
`else
  // Fixed latency: the final step is always i = WIDTH-1.
  always_comb begin
    last_step = (cnt_reg == LAST_STEP);
  end
`endif

  // Next-state and datapath update; defaults hold every register.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    prod_next  = prod_reg;
    exc_next   = exc_reg;
    rdy_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ctrl_start) begin
          a_next     = data_operandA;
          b_next     = {data_operandB, 1'b0};
          acc_next   = '0;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next = acc_step;
        cnt_next = cnt_reg + 1'b1;
        if (last_step) begin
          prod_next  = acc_step;
          exc_next   = ~((&prod_top) | ~(|prod_top));
          rdy_next   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      prod_reg  <= '0;
      exc_reg   <= 1'b0;
      rdy_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      prod_reg  <= prod_next;
      exc_reg   <= exc_next;
      rdy_reg   <= rdy_next;
    end
  end

  assign data_product   = prod_reg;
  assign data_result    = prod_reg[WIDTH-1:0];
  assign data_exception = exc_reg;
  assign data_resultRDY = rdy_reg;
  assign busy           = (state_reg == RUN);

endmodule
